// File: rtl/reg_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : reg_cmd_parser
// Description : Byte-stream command parser. It accepts frames of the form
//               HDR(0xA5), ADDR, DATA, CHK with CHK = 0xA5 ^ ADDR ^ DATA.
//               Each valid frame turns into a one-cycle register-file write.
//               Frames with an address error, a checksum error or an
//               inter-byte timeout produce a one-cycle err pulse with a cause.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous reset, active low
//               in_data    - incoming byte
//               in_valid   - in_data valid
//               in_ready   - parser accepts a byte (valid & ready on edge)
//               wr_en      - one-cycle write strobe
//               wr_addr    - write address (holds last committed value)
//               wr_data    - write data (holds last committed value)
//               err        - one-cycle reject pulse
//               err_code   - last error cause: 01 addr, 10 checksum, 11 timeout
//               good_cnt   - committed writes, saturating at 255
// Revision    : 1.0 - initial release
// ============================================================================
module reg_cmd_parser #(
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [7:0]        good_cnt
);

  localparam logic [WIDTH-1:0] c_HDR = WIDTH'(8'hA5);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // The counter "reaches" TIMEOUT on the edge where it would step from
  // TIMEOUT-1 to TIMEOUT, so the timeout fires after exactly TIMEOUT idle
  // cycles rather than TIMEOUT+1.
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] c_ERR_ADDR = 2'b01;
  localparam logic [1:0] c_ERR_CHK  = 2'b10;
  localparam logic [1:0] c_ERR_TO   = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    GET_CHK  = 3'd3,
    WRITE    = 3'd4
  } state_t;

  state_t              state_q,    state_d;
  logic [WIDTH-1:0]    addr_q,     addr_d;
  logic [WIDTH-1:0]    data_q,     data_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [ADDR_W-1:0]   wr_addr_q,  wr_addr_d;
  logic [WIDTH-1:0]    wr_data_q,  wr_data_d;
  logic                err_q,      err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [7:0]          good_cnt_q, good_cnt_d;

  logic w_accept;
  logic w_addr_err;
  logic w_timeout;
  logic [WIDTH-1:0] w_chk_exp;

  // Ready is gated by reset so nothing is accepted while rst is held low.
  assign in_ready   = rst && (state_q != WRITE);
  assign w_accept   = in_valid && in_ready;
  // Any bit above the register address range marks the address invalid.
  assign w_addr_err = |(addr_q >> ADDR_W);
  assign w_timeout  = (cnt_q == c_CNT_LAST);
  assign w_chk_exp  = c_HDR ^ addr_q ^ data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      good_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      good_cnt_q <= good_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = '0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    good_cnt_d = good_cnt_q;

    case (state_q)
      IDLE: begin
        // Non-header bytes are dropped without complaint.
        if (w_accept && (in_data == c_HDR)) begin
          state_d = GET_ADDR;
        end
      end

      GET_ADDR: begin
        if (w_accept) begin
          addr_d  = in_data;
          state_d = GET_DATA;
        end else if (w_timeout) begin
          err_d      = 1'b1;
          err_code_d = c_ERR_TO;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      GET_DATA: begin
        if (w_accept) begin
          data_d  = in_data;
          state_d = GET_CHK;
        end else if (w_timeout) begin
          err_d      = 1'b1;
          err_code_d = c_ERR_TO;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      GET_CHK: begin
        if (w_accept) begin
          // Address error outranks a checksum error.
          if (w_addr_err) begin
            err_d      = 1'b1;
            err_code_d = c_ERR_ADDR;
            state_d    = IDLE;
          end else if (in_data != w_chk_exp) begin
            err_d      = 1'b1;
            err_code_d = c_ERR_CHK;
            state_d    = IDLE;
          end else begin
            // Load the write bus on entry so it is valid for the whole
            // WRITE cycle and then simply holds afterwards.
            wr_addr_d = addr_q[ADDR_W-1:0];
            wr_data_d = data_q;
            state_d   = WRITE;
          end
        end else if (w_timeout) begin
          err_d      = 1'b1;
          err_code_d = c_ERR_TO;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WRITE: begin
        if (good_cnt_q != 8'hFF) begin
          good_cnt_d = good_cnt_q + 8'd1;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wr_en    = (state_q == WRITE);
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign good_cnt = good_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_cmd_parser
// Description : Directed self-checking bench for reg_cmd_parser.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_cmd_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] good_cnt;

  int cmp_cnt  = 0;
  int mism_cnt = 0;

  // Running event counters, sampled on the falling edge.
  int         mon_wr      = 0;
  int         mon_err     = 0;
  int         mon_both    = 0;
  int         mon_rdy_low = 0;
  logic [3:0] mon_addr    = 4'h0;
  logic [7:0] mon_data    = 8'h00;

  reg_cmd_parser #(
    .WIDTH  (8),
    .ADDR_W (4),
    .TIMEOUT(255)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .err      (err),
    .err_code (err_code),
    .good_cnt (good_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (wr_en) begin
        mon_wr   = mon_wr + 1;
        mon_addr = wr_addr;
        mon_data = wr_data;
      end
      if (err)          mon_err     = mon_err + 1;
      if (wr_en && err) mon_both    = mon_both + 1;
      if (!in_ready)    mon_rdy_low = mon_rdy_low + 1;
    end
  end

  // Present a byte and hold it until accepted; returns 1 ns after the edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      cmp_cnt++; mism_cnt++;
      $display("FAIL send_byte_ready: in_ready stayed %0b for byte %02h, want 1", in_ready, b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d);
    send_byte(c);
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    cmp_cnt++; if (in_ready !== 1'b0) begin mism_cnt++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    cmp_cnt++; if (wr_en !== 1'b0)    begin mism_cnt++; $display("FAIL rst_wr_en: got %0b want 0", wr_en); end
    cmp_cnt++; if (err !== 1'b0)      begin mism_cnt++; $display("FAIL rst_err: got %0b want 0", err); end
    cmp_cnt++; if (wr_addr !== 4'h0)  begin mism_cnt++; $display("FAIL rst_wr_addr: got %h want 0", wr_addr); end
    cmp_cnt++; if (wr_data !== 8'h00) begin mism_cnt++; $display("FAIL rst_wr_data: got %h want 00", wr_data); end
    cmp_cnt++; if (err_code !== 2'b00) begin mism_cnt++; $display("FAIL rst_err_code: got %b want 00", err_code); end
    cmp_cnt++; if (good_cnt !== 8'd0) begin mism_cnt++; $display("FAIL rst_good_cnt: got %0d want 0", good_cnt); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    cmp_cnt++; if (in_ready !== 1'b1) begin mism_cnt++; $display("FAIL rst_release_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_basic_write();
    int w0, e0;
    w0 = mon_wr; e0 = mon_err;
    send_frame(8'h03, 8'h5C, 8'hFA);
    @(negedge clk);
    cmp_cnt++; if (wr_en !== 1'b1)    begin mism_cnt++; $display("FAIL basic_wr_en: got %0b want 1", wr_en); end
    cmp_cnt++; if (in_ready !== 1'b0) begin mism_cnt++; $display("FAIL basic_ready_in_write: got %0b want 0", in_ready); end
    cmp_cnt++; if (wr_addr !== 4'h3)  begin mism_cnt++; $display("FAIL basic_wr_addr: got %h want 3", wr_addr); end
    cmp_cnt++; if (wr_data !== 8'h5C) begin mism_cnt++; $display("FAIL basic_wr_data: got %h want 5c", wr_data); end
    @(negedge clk);
    cmp_cnt++; if (wr_en !== 1'b0)    begin mism_cnt++; $display("FAIL basic_wr_en_drop: got %0b want 0", wr_en); end
    cmp_cnt++; if (in_ready !== 1'b1) begin mism_cnt++; $display("FAIL basic_ready_back: got %0b want 1", in_ready); end
    cmp_cnt++; if (wr_addr !== 4'h3)  begin mism_cnt++; $display("FAIL basic_addr_hold: got %h want 3", wr_addr); end
    @(posedge clk);
    #1;
    cmp_cnt++; if (mon_wr - w0 !== 1)  begin mism_cnt++; $display("FAIL basic_wr_pulses: got %0d want 1", mon_wr - w0); end
    cmp_cnt++; if (mon_err - e0 !== 0) begin mism_cnt++; $display("FAIL basic_err_pulses: got %0d want 0", mon_err - e0); end
    cmp_cnt++; if (good_cnt !== 8'd1)  begin mism_cnt++; $display("FAIL basic_good_cnt: got %0d want 1", good_cnt); end
  endtask

  task automatic test_bad_checksum();
    int w0, e0;
    w0 = mon_wr; e0 = mon_err;
    send_frame(8'h03, 8'h5C, 8'h00);
    @(negedge clk);
    cmp_cnt++; if (err !== 1'b1)       begin mism_cnt++; $display("FAIL chk_err: got %0b want 1", err); end
    cmp_cnt++; if (err_code !== 2'b10) begin mism_cnt++; $display("FAIL chk_err_code: got %b want 10", err_code); end
    cmp_cnt++; if (wr_en !== 1'b0)     begin mism_cnt++; $display("FAIL chk_wr_en: got %0b want 0", wr_en); end
    @(posedge clk);
    #1;
    cmp_cnt++; if (mon_wr - w0 !== 0)  begin mism_cnt++; $display("FAIL chk_wr_pulses: got %0d want 0", mon_wr - w0); end
    cmp_cnt++; if (mon_err - e0 !== 1) begin mism_cnt++; $display("FAIL chk_err_pulses: got %0d want 1", mon_err - e0); end
    cmp_cnt++; if (good_cnt !== 8'd1)  begin mism_cnt++; $display("FAIL chk_good_cnt: got %0d want 1", good_cnt); end
  endtask

  task automatic test_addr_error();
    int w0;
    w0 = mon_wr;
    send_frame(8'h13, 8'h00, 8'hB6);
    @(negedge clk);
    cmp_cnt++; if (err !== 1'b1)       begin mism_cnt++; $display("FAIL addr_err: got %0b want 1", err); end
    cmp_cnt++; if (err_code !== 2'b01) begin mism_cnt++; $display("FAIL addr_err_code: got %b want 01", err_code); end
    cmp_cnt++; if (wr_en !== 1'b0)     begin mism_cnt++; $display("FAIL addr_wr_en: got %0b want 0", wr_en); end
    // Bad checksum too: the address error must still be the reported cause.
    send_frame(8'h20, 8'h00, 8'h00);
    @(negedge clk);
    cmp_cnt++; if (err_code !== 2'b01) begin mism_cnt++; $display("FAIL addr_prio_code: got %b want 01", err_code); end
    @(negedge clk);
    cmp_cnt++; if (err !== 1'b0)       begin mism_cnt++; $display("FAIL addr_err_pulse_len: got %0b want 0", err); end
    cmp_cnt++; if (err_code !== 2'b01) begin mism_cnt++; $display("FAIL addr_code_hold: got %b want 01", err_code); end
    cmp_cnt++; if (mon_wr - w0 !== 0)  begin mism_cnt++; $display("FAIL addr_wr_pulses: got %0d want 0", mon_wr - w0); end
  endtask

  task automatic test_timeout();
    int   w0;
    logic early;
    early = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h07);
    // 255 idle cycles: the err pulse appears in the cycle after the 255th.
    for (int k = 0; k < 255; k++) begin
      @(negedge clk);
      if (err) early = 1'b1;
    end
    cmp_cnt++; if (early !== 1'b0) begin mism_cnt++; $display("FAIL to_early_err: got %0b want 0", early); end
    @(negedge clk);
    cmp_cnt++; if (err !== 1'b1)       begin mism_cnt++; $display("FAIL to_err: got %0b want 1", err); end
    cmp_cnt++; if (err_code !== 2'b11) begin mism_cnt++; $display("FAIL to_err_code: got %b want 11", err_code); end
    w0 = mon_wr;
    send_byte(8'h11);
    send_frame(8'h0F, 8'hAA, 8'h00);
    @(negedge clk);
    @(posedge clk);
    #1;
    cmp_cnt++; if (mon_wr - w0 !== 1)  begin mism_cnt++; $display("FAIL to_recover_wr: got %0d want 1", mon_wr - w0); end
    cmp_cnt++; if (mon_addr !== 4'hF)  begin mism_cnt++; $display("FAIL to_recover_addr: got %h want f", mon_addr); end
    cmp_cnt++; if (mon_data !== 8'hAA) begin mism_cnt++; $display("FAIL to_recover_data: got %h want aa", mon_data); end
    cmp_cnt++; if (good_cnt !== 8'd2)  begin mism_cnt++; $display("FAIL to_good_cnt: got %0d want 2", good_cnt); end
  endtask

  task automatic test_timeout_priority();
    int w0, e0;
    w0 = mon_wr; e0 = mon_err;
    send_byte(8'hA5);
    // ADDR byte lands on the same edge the counter reaches TIMEOUT.
    repeat (255) @(negedge clk);
    send_byte(8'h01);
    send_byte(8'h22);
    send_byte(8'h86);
    @(negedge clk);
    @(posedge clk);
    #1;
    cmp_cnt++; if (mon_err - e0 !== 0) begin mism_cnt++; $display("FAIL prio_err_pulses: got %0d want 0", mon_err - e0); end
    cmp_cnt++; if (mon_wr - w0 !== 1)  begin mism_cnt++; $display("FAIL prio_wr_pulses: got %0d want 1", mon_wr - w0); end
    cmp_cnt++; if (mon_addr !== 4'h1)  begin mism_cnt++; $display("FAIL prio_addr: got %h want 1", mon_addr); end
    cmp_cnt++; if (mon_data !== 8'h22) begin mism_cnt++; $display("FAIL prio_data: got %h want 22", mon_data); end
  endtask

  task automatic test_reset_midframe();
    int w0, e0;
    w0 = mon_wr; e0 = mon_err;
    send_byte(8'hA5);
    send_byte(8'h02);
    rst = 1'b0;
    @(negedge clk);
    cmp_cnt++; if (in_ready !== 1'b0) begin mism_cnt++; $display("FAIL midrst_ready: got %0b want 0", in_ready); end
    cmp_cnt++; if (good_cnt !== 8'd0) begin mism_cnt++; $display("FAIL midrst_good_cnt: got %0d want 0", good_cnt); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_frame(8'h02, 8'h11, 8'hB6);
    @(negedge clk);
    @(posedge clk);
    #1;
    cmp_cnt++; if (mon_wr - w0 !== 1)  begin mism_cnt++; $display("FAIL midrst_wr_pulses: got %0d want 1", mon_wr - w0); end
    cmp_cnt++; if (mon_err - e0 !== 0) begin mism_cnt++; $display("FAIL midrst_err_pulses: got %0d want 0", mon_err - e0); end
    cmp_cnt++; if (mon_addr !== 4'h2)  begin mism_cnt++; $display("FAIL midrst_addr: got %h want 2", mon_addr); end
    cmp_cnt++; if (mon_data !== 8'h11) begin mism_cnt++; $display("FAIL midrst_data: got %h want 11", mon_data); end
    cmp_cnt++; if (good_cnt !== 8'd1)  begin mism_cnt++; $display("FAIL midrst_good_cnt_after: got %0d want 1", good_cnt); end
  endtask

  task automatic test_back_to_back();
    int         w0, e0, r0;
    logic [7:0] a, d;
    w0 = mon_wr; e0 = mon_err; r0 = mon_rdy_low;
    for (int i = 0; i < 260; i++) begin
      a = 8'(i % 16);
      d = 8'(i) ^ 8'h3C;
      send_frame(a, d, 8'hA5 ^ a ^ d);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    cmp_cnt++; if (mon_wr - w0 !== 260)      begin mism_cnt++; $display("FAIL b2b_wr_pulses: got %0d want 260", mon_wr - w0); end
    cmp_cnt++; if (mon_rdy_low - r0 !== 260) begin mism_cnt++; $display("FAIL b2b_ready_low: got %0d want 260", mon_rdy_low - r0); end
    cmp_cnt++; if (mon_err - e0 !== 0)       begin mism_cnt++; $display("FAIL b2b_err_pulses: got %0d want 0", mon_err - e0); end
    cmp_cnt++; if (good_cnt !== 8'd255)      begin mism_cnt++; $display("FAIL b2b_good_cnt_sat: got %0d want 255", good_cnt); end
    cmp_cnt++; if (mon_addr !== 4'h3)        begin mism_cnt++; $display("FAIL b2b_last_addr: got %h want 3", mon_addr); end
    cmp_cnt++; if (mon_data !== 8'h3F)       begin mism_cnt++; $display("FAIL b2b_last_data: got %h want 3f", mon_data); end
    cmp_cnt++; if (mon_both !== 0)           begin mism_cnt++; $display("FAIL err_wr_overlap: got %0d want 0", mon_both); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_bad_checksum();
    test_addr_error();
    test_timeout();
    test_timeout_priority();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mism_cnt);
    $finish;
  end

endmodule
`default_nettype wire
